// File: rtl/shift_issue_pipe.sv
// Two-stage issue pipeline in front of an external combinational shifter.
// S1 registers the decoded shift request; S2 captures the shifter result for the consumer.
`timescale 1ns/1ps

module shift_issue_pipe #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sh_x,
    output logic [4:0]       sh_s,
    output logic             sh_left,
    output logic             sh_log,
    input  logic [31:0]      sh_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      ops_done
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;

    logic             r_s1_valid;
    logic [31:0]      r_sh_x;
    logic [4:0]       r_sh_s;
    logic             r_sh_left;
    logic             r_sh_log;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_err;

    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
    logic [15:0]      r_ops_done;

    logic             w_s2_load;
    logic             w_accept;
    logic             w_drain;
    logic             w_dec_left;
    logic             w_dec_log;
    logic [4:0]       w_dec_s;
    logic             w_dec_err;
    logic             w_unused_b;

    // Upper shift-amount bits are architecturally ignored.
    assign w_unused_b = ^in_b[31:5];

    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign w_drain   = r_out_valid && out_ready;
    assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_dec_left = 1'b0;
        w_dec_log  = 1'b1;
        w_dec_s    = in_b[4:0];
        w_dec_err  = 1'b0;
        unique case (in_op)
            OpSll: begin
                w_dec_left = 1'b1;
                w_dec_log  = 1'b1;
            end
            OpSrl: begin
                w_dec_left = 1'b0;
                w_dec_log  = 1'b1;
            end
            OpSra: begin
                w_dec_left = 1'b0;
                w_dec_log  = 1'b0;
            end
            default: begin
                // Zero-distance logical right shift passes the operand through unchanged.
                w_dec_s   = 5'd0;
                w_dec_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_sh_x      <= '0;
            r_sh_s      <= '0;
            r_sh_left   <= 1'b0;
            r_sh_log    <= 1'b0;
            r_s1_tag    <= '0;
            r_s1_err    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_sh_x     <= in_a;
                r_sh_s     <= w_dec_s;
                r_sh_left  <= w_dec_left;
                r_sh_log   <= w_dec_log;
                r_s1_tag   <= in_tag;
                r_s1_err   <= w_dec_err;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= sh_z;
                r_out_tag   <= r_s1_tag;
                r_out_err   <= r_s1_err;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            if (w_drain) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign sh_x      = r_sh_x;
    assign sh_s      = r_sh_s;
    assign sh_left   = r_sh_left;
    assign sh_log    = r_sh_log;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_shift_issue_pipe.sv
// Self-checking bench for shift_issue_pipe: a behavioural shifter closes the loop and a
// scoreboard of expected results is compared in order as results are consumed.
`timescale 1ns/1ps

module tb_shift_issue_pipe;

    localparam int unsigned TW = 4;
    localparam int unsigned SendBound = 50;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic [TW-1:0] in_tag;
    logic [31:0]   sh_x;
    logic [4:0]    sh_s;
    logic          sh_left;
    logic          sh_log;
    logic [31:0]   sh_z;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;
    logic [15:0]   ops_done;

    int checks;
    int errors;
    int n_done;
    int cyc;
    logic [36:0] sb[$];

    shift_issue_pipe #(.TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .sh_x      (sh_x),
        .sh_s      (sh_s),
        .sh_left   (sh_left),
        .sh_log    (sh_log),
        .sh_z      (sh_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: the external combinational shifter.
    always_comb begin
        if (sh_left)     sh_z = sh_x << sh_s;
        else if (sh_log) sh_z = sh_x >> sh_s;
        else             sh_z = 32'($signed(sh_x) >>> sh_s);
    end

    function automatic logic [36:0] expect_res(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [TW-1:0] tag);
        logic [31:0] d;
        logic        e;
        e = 1'b0;
        case (op)
            2'b00:   d = a << b[4:0];
            2'b01:   d = a >> b[4:0];
            2'b10:   d = 32'($signed(a) >>> b[4:0]);
            default: begin d = a; e = 1'b1; end
        endcase
        return {e, tag, d};
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [36:0] exp_v;
        if (rst) begin
            sb.delete();
            n_done = 0;
        end else begin
            checks++;
            if (ops_done !== n_done[15:0]) begin
                errors++;
                $display("FAIL ops_done_count: got %h expected %h", ops_done, n_done[15:0]);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got data=%h tag=%h err=%b, none expected",
                             out_data, out_tag, out_err);
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_err, out_tag, out_data} !== exp_v) begin
                        errors++;
                        $display("FAIL result_order: got err=%b tag=%h data=%h expected err=%b tag=%h data=%h",
                                 out_err, out_tag, out_data, exp_v[36], exp_v[35:32], exp_v[31:0]);
                    end
                end
                n_done++;
            end
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(expect_res(in_op, in_a, in_b, in_tag));
            end
        end
    end

    // Offers one op and returns #1 after the edge on which it was accepted.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int k = 0; k < SendBound; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: op=%b a=%h never accepted within %0d cycles", op, a, SendBound);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, out_err, out_tag, out_data} !== 38'd0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b err=%b tag=%h data=%h expected all zero",
                     out_valid, out_err, out_tag, out_data);
        end
        checks++;
        if ({sh_x, sh_s, sh_left, sh_log} !== 39'd0) begin
            errors++;
            $display("FAIL reset_sh: got x=%h s=%h left=%b log=%b expected all zero",
                     sh_x, sh_s, sh_left, sh_log);
        end
        checks++;
        if (ops_done !== 16'd0) begin
            errors++;
            $display("FAIL reset_ops_done: got %h expected 0000", ops_done);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_sll_latency;
        out_ready = 1'b1;
        send(2'b00, 32'h0000_0001, 32'd4, 4'd3);
        in_valid = 1'b0;
        checks++;
        if ({sh_x, sh_s, sh_left, sh_log, out_valid} !== {32'h1, 5'd4, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sll_issue: got x=%h s=%0d left=%b log=%b ovalid=%b expected 1/4/1/1/0",
                     sh_x, sh_s, sh_left, sh_log, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_tag, out_err} !== {1'b1, 32'h10, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL sll_result: got valid=%b data=%h tag=%h err=%b expected 1/00000010/3/0",
                     out_valid, out_data, out_tag, out_err);
        end
        idle(2);
    endtask

    task automatic test_sra_srl;
        out_ready = 1'b1;
        send(2'b10, 32'h8000_0000, 32'd31, 4'd1);
        send(2'b01, 32'h8000_0000, 32'd31, 4'd2);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL sra_result: got valid=%b data=%h expected 1/ffffffff", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h0000_0001}) begin
            errors++;
            $display("FAIL srl_result: got valid=%b data=%h expected 1/00000001", out_valid, out_data);
        end
        idle(2);
    endtask

    task automatic test_srl_masked;
        out_ready = 1'b1;
        send(2'b01, 32'hF000_0000, 32'hFFFF_FFE4, 4'd9);
        in_valid = 1'b0;
        checks++;
        if ({sh_s, sh_left, sh_log} !== {5'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL srl_mask_issue: got s=%0d left=%b log=%b expected 4/0/1", sh_s, sh_left, sh_log);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 32'h0F00_0000) begin
            errors++;
            $display("FAIL srl_mask_result: got %h expected 0f000000", out_data);
        end
        idle(2);
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send(2'b11, 32'h1234_5678, 32'd7, 4'd12);
        in_valid = 1'b0;
        checks++;
        if ({sh_x, sh_s, sh_left, sh_log} !== {32'h1234_5678, 5'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_issue: got x=%h s=%0d left=%b log=%b expected 12345678/0/0/1",
                     sh_x, sh_s, sh_left, sh_log);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_err} !== {1'b1, 32'h1234_5678, 1'b1}) begin
            errors++;
            $display("FAIL illegal_result: got valid=%b data=%h err=%b expected 1/12345678/1",
                     out_valid, out_data, out_err);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send(2'(i % 3), 32'hA5A5_0000 + 32'(i), 32'(i * 3), 4'(i));
        end
        in_valid = 1'b0;
        checks++;
        if (cyc - c0 !== 8) begin
            errors++;
            $display("FAIL throughput: got %0d cycles for 8 ops expected 8", cyc - c0);
        end
        idle(3);
    endtask

    task automatic test_backpressure;
        int base;
        base = n_done;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 2'b00; in_a = 32'h1;         in_b = 32'd1; in_tag = 4'd5;
        @(posedge clk);
        #1;
        in_op = 2'b01; in_a = 32'h100;       in_b = 32'd4; in_tag = 4'd6;
        @(posedge clk);
        #1;
        in_op = 2'b10; in_a = 32'h8000_0000; in_b = 32'd4; in_tag = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_data, out_tag} !== {1'b0, 1'b1, 32'h2, 4'd5}) begin
                errors++;
                $display("FAIL bp_hold: got ready=%b valid=%b data=%h tag=%h expected 0/1/00000002/5",
                         in_ready, out_valid, out_data, out_tag);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h10) begin
            errors++;
            $display("FAIL bp_second: got %h expected 00000010", out_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 32'hF800_0000) begin
            errors++;
            $display("FAIL bp_third: got %h expected f8000000", out_data);
        end
        idle(3);
        checks++;
        if (ops_done !== 16'(base + 3)) begin
            errors++;
            $display("FAIL bp_ops_done: got %h expected %h", ops_done, 16'(base + 3));
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 2'($urandom_range(0, 3));
            in_a      = $urandom;
            in_b      = $urandom;
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d results outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_wrap;
        int remaining;
        out_ready = 1'b1;
        remaining = 65536 - (n_done % 65536);
        for (int i = 0; i < remaining; i++) begin
            send(2'b00, 32'(i), 32'(i), 4'(i));
        end
        idle(4);
        checks++;
        if (ops_done !== 16'h0000) begin
            errors++;
            $display("FAIL ops_done_wrap: got %h expected 0000", ops_done);
        end
    endtask

    task automatic test_reset_inflight;
        out_ready = 1'b0;
        send(2'b00, 32'h3, 32'd2, 4'd1);
        send(2'b01, 32'h30, 32'd2, 4'd2);
        in_valid = 1'b1;
        in_op = 2'b00; in_a = 32'hDEAD_BEEF; in_b = 32'd1; in_tag = 4'd3;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, ops_done, in_ready} !== {1'b0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_inflight: got valid=%b ops_done=%h ready=%b expected 0/0000/1",
                     out_valid, ops_done, in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale: got out_valid=%b data=%h expected 0", out_valid, out_data);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_done = 0;
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        test_reset();
        test_sll_latency();
        test_sra_srl();
        test_srl_masked();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_issue_pipe.md
SHIFT_ISSUE_PIPE -- requirements
Module: shift_issue_pipe

Interface
REQ-001 The block SHALL have one parameter: TAG_W, default 4, width of the operation tag carried alongside each operation.
REQ-002 The block SHALL have clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have rst, input, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have in_valid, input, 1 bit, indicating an upstream operation is offered.
REQ-005 The block SHALL have in_ready, output, 1 bit, indicating the block accepts the offered operation this cycle.
REQ-006 The block SHALL have in_op, input, 2 bits, the opcode: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-007 The block SHALL have in_a, input, 32 bits, the data operand.
REQ-008 The block SHALL have in_b, input, 32 bits, the shift-amount operand; only bits [4:0] are used.
REQ-009 The block SHALL have in_tag, input, TAG_W bits, an opaque operation tag.
REQ-010 The block SHALL have sh_x (32), sh_s (5), sh_left (1) and sh_log (1), all outputs, driving the X, S, LEFT and LOG inputs of the combinational shifter.
REQ-011 The block SHALL have sh_z, input, 32 bits, the shifter result Z.
REQ-012 The block SHALL have out_valid, output, 1 bit, indicating a result is presented.
REQ-013 The block SHALL have out_ready, input, 1 bit, indicating the downstream stage accepts the result.
REQ-014 The block SHALL have out_data (32), out_tag (TAG_W) and out_err (1), all outputs, carrying the result, its tag and the illegal-op flag.
REQ-015 The block SHALL have ops_done, output, 16 bits, a count of results accepted downstream.

Function
REQ-016 The block SHALL be a two-stage pipeline: S1 is the issue register driving sh_*, and S2 is the result register driving out_*.
REQ-017 A transfer SHALL occur on any edge where in_valid && in_ready.
- On transfer, S1 SHALL capture the decoded operation and tag, and set s1_valid.
REQ-018 Decode SHALL be as follows:
- SLL: sh_left=1, sh_log=1.
- SRL: sh_left=0, sh_log=1.
- SRA: sh_left=0, sh_log=0.
- In all three cases sh_x=in_a and sh_s=in_b[4:0].
REQ-019 Illegal op 11 SHALL decode to sh_left=0, sh_log=1, sh_s=0, sh_x=in_a, and set the S1 error bit.
- The shifter then returns in_a unchanged.
REQ-020 sh_* SHALL be driven directly from S1 registers, with no combinational path from in_* to sh_*.
REQ-021 S2 SHALL load sh_z, the S1 tag and the S1 error bit when s1_valid && (!out_valid || out_ready).
- S1 SHALL empty in that cycle unless it is refilled at the same edge.
REQ-022 in_ready SHALL equal !s1_valid || !out_valid || out_ready.
REQ-023 Latency SHALL be exactly 2 cycles: an operation accepted at edge N SHALL present out_valid=1 after edge N+1 when no backpressure is applied.
REQ-024 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-025 While out_valid=1 && out_ready=0, S2 outputs SHALL hold stable.
- S1 SHALL retain at most one additional operation; no operation SHALL be dropped or duplicated.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 Simultaneous S2 drain, S1-to-S2 move and new acceptance in one cycle SHALL all take effect at that edge.
REQ-028 ops_done SHALL increment on each out_valid && out_ready edge and wrap from 0xFFFF to 0x0000.
REQ-029 The sh_* registers SHALL hold their last values when S1 is empty.

Reset
REQ-030 While rst=1 at an edge, the following SHALL clear to 0:
- s1_valid, out_valid, out_data, out_tag, out_err, ops_done and all sh_* outputs.
REQ-031 Reset SHALL override simultaneous transfers; operations in flight at reset SHALL be discarded without producing output.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 SLL with in_a=0x00000001, in_b=4, tag=3, out_ready=1 -> out_data=0x00000010, out_tag=3, out_err=0, two cycles after acceptance.
REQ-034 SRA then SRL with in_a=0x80000000, in_b=31 -> out_data=0xFFFFFFFF, then 0x00000001, in order on consecutive cycles.
REQ-035 SRL with in_a=0xF0000000, in_b=0xFFFFFFE4 -> sh_s=4, out_data=0x0F000000.
REQ-036 Three back-to-back ops with out_ready=0 -> two accepted, then in_ready=0; out_data held. Raising out_ready -> all three emerge in order, and ops_done advances by 3.
REQ-037 in_op=11, in_a=0x12345678, in_b=7 -> out_data=0x12345678, out_err=1.
REQ-038 rst pulsed with both stages full -> next cycle out_valid=0, ops_done=0, in_ready=1; no stale result appears afterward.
